fp16_accumulator: RTL

Streaming half-precision accumulator that sits directly downstream of the combinational `fpadder` and drives it. It accepts a valid/ready stream of FP16 operands, each tagged add or subtract, and folds every element into a registered running sum through one `fpadder` instance at one element per cycle. On the element marked last it presents the final sum, element count and an overflow flag on a valid/ready output port. It then clears itself for the next stream.

---
 rtl/fp16_pkg.sv | 22 ++
 rtl/fpadder.sv | 68 ++++++
 rtl/fp16_accumulator.sv | 69 ++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, sign helper and accumulator state type.
package fp16_pkg;
  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [EXP_W-1:0]  EXP_ALL_ONES = 5'h1F;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  function automatic logic [FP16_W-1:0] sign_flip(
    input logic [FP16_W-1:0] x,
    input logic              flip
  );
    return {x[FP16_W-1] ^ flip, x[FP16_W-2:0]};
  endfunction
endpackage

// File: rtl/fpadder.sv
// Combinational binary16 adder/subtractor, round-to-nearest-even.
// Handles subnormals; Inf passes through, invalid ops give a quiet NaN.
module fpadder
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  input  logic              sub,
  output logic [FP16_W-1:0] s
);
  logic              sa, sb, sx, sy, swap;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0]  ea, eb, ex, ey, d, lz, ls, ef;
  logic [MAN_W:0]    fa, fb, fx, fy;
  logic [26:0]       sh;
  logic [14:0]       mx, my, r, rnd;
  logic [13:0]       n;
  logic [EXP_W:0]    en;
  logic              up, zs;

  always_comb begin
    sa    = a[15];
    sb    = b[15] ^ sub;
    a_inf = (a[14:10] == EXP_ALL_ONES) && (a[9:0] == '0);
    b_inf = (b[14:10] == EXP_ALL_ONES) && (b[9:0] == '0);
    a_nan = (a[14:10] == EXP_ALL_ONES) && (a[9:0] != '0);
    b_nan = (b[14:10] == EXP_ALL_ONES) && (b[9:0] != '0);
    ea    = (a[14:10] == '0) ? 5'd1 : a[14:10];
    eb    = (b[14:10] == '0) ? 5'd1 : b[14:10];
    fa    = {|a[14:10], a[9:0]};
    fb    = {|b[14:10], b[9:0]};
    swap  = b[14:0] > a[14:0];
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    fx    = swap ? fb : fa;
    fy    = swap ? fa : fb;
    d     = ex - ey;
    // guard, round and sticky bits sit below the aligned mantissa
    sh    = {fy, 16'b0} >> d;
    mx    = {1'b0, fx, 3'b000};
    my    = {1'b0, sh[26:14], sh[13] | (|sh[12:0])};
    r     = (sx == sy) ? mx + my : mx - my;
    lz    = 5'd14;
    for (int i = 0; i <= 13; i++) begin
      if (r[i]) lz = 5'(13 - i);
    end
    ls = (lz > ex - 5'd1) ? ex - 5'd1 : lz;
    if (r[14]) begin
      n  = {r[14:2], r[1] | r[0]};
      en = {1'b0, ex} + 6'd1;
    end else begin
      n  = r[13:0] << ls;
      en = {1'b0, ex} - {1'b0, ls};
    end
    up  = n[2] & (n[1] | n[0] | n[3]);
    ef  = n[13] ? en[4:0] : 5'd0;
    rnd = {ef, n[12:3]} + {14'b0, up};
    zs  = (sx == sy) ? sx : 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) s = FP16_QNAN;
    else if (a_inf)                                    s = a;
    else if (b_inf)                                    s = {sb, 15'h7C00};
    else if (en >= 6'd31)                              s = {sx, 15'h7C00};
    else if (r == '0)                                  s = {zs, 15'h0000};
    else                                               s = {sx, rnd};
  end
endmodule

// File: rtl/fp16_accumulator.sv
// Streaming FP16 accumulator: folds a valid/ready operand stream into
// one running sum and hands out sum, count and overflow flag.
module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_inf
);
  acc_state_t        state_q;
  logic [FP16_W-1:0] acc_q, acc_d, sum_w;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inf_q, first_q;

  fpadder u_add (
    .a   (acc_q),
    .b   (in_data),
    .sub (in_sub),
    .s   (sum_w)
  );

  // first operand bypasses the adder so no -0 or 0+x artefacts appear
  assign acc_d   = first_q ? sign_flip(in_data, in_sub) : sum_w;
  assign count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= FP16_ZERO;
      count_q <= '0;
      inf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      unique case (state_q)
        ACCUM: if (in_valid) begin
          acc_q   <= acc_d;
          count_q <= count_d;
          inf_q   <= inf_q | (acc_d[14:10] == EXP_ALL_ONES);
          first_q <= 1'b0;
          if (in_last) state_q <= DONE;
        end
        DONE: if (out_ready) begin
          state_q <= ACCUM;
          acc_q   <= FP16_ZERO;
          count_q <= '0;
          inf_q   <= 1'b0;
          first_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_inf   = inf_q;
endmodule
